// File: rtl/mux2v1_arb.sv
// Two-input packet-locked stream arbiter with round-robin tie-break and a one-beat output register.
// Optional per-input packet counters are enabled by defining MUX2V1_ARB_CNT_EN.
module mux2v1_arb #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] E0_data,
    input  logic             E0_valid,
    input  logic             E0_last,
    output logic             E0_ready,
    input  logic [WIDTH-1:0] E1_data,
    input  logic             E1_valid,
    input  logic             E1_last,
    output logic             E1_ready,
`ifdef MUX2V1_ARB_CNT_EN
    output logic [15:0]      cnt0,
    output logic [15:0]      cnt1,
`endif
    output logic [WIDTH-1:0] S_data,
    output logic             S_valid,
    output logic             S_last,
    output logic             S_src,
    input  logic             S_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             ptr_q, ptr_d;
    logic             s_valid_q, s_valid_d;
    logic             s_last_q, s_last_d;
    logic             s_src_q, s_src_d;
    logic [WIDTH-1:0] s_data_q, s_data_d;

    logic grant0, grant1;
    logic can_load;
    logic acc0, acc1, acc;
    logic sel_last;

    // Grant: locked input owns the output until its last beat; otherwise round-robin on ties.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        case (state_q)
            IDLE: begin
                grant0 = E0_valid & (~E1_valid | ~ptr_q);
                grant1 = E1_valid & (~E0_valid | ptr_q);
            end
            LOCK0:   grant0 = 1'b1;
            LOCK1:   grant1 = 1'b1;
            default: ;
        endcase
    end

    assign can_load = ~s_valid_q | S_ready;
    assign E0_ready = grant0 & can_load;
    assign E1_ready = grant1 & can_load;
    assign acc0     = E0_valid & E0_ready;
    assign acc1     = E1_valid & E1_ready;
    assign acc      = acc0 | acc1;
    assign sel_last = acc1 ? E1_last : E0_last;

    // Output register and lock/pointer update.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        s_valid_d = s_valid_q;
        s_last_d  = s_last_q;
        s_src_d   = s_src_q;
        s_data_d  = s_data_q;
        if (acc) begin
            s_valid_d = 1'b1;
            s_data_d  = acc1 ? E1_data : E0_data;
            s_last_d  = sel_last;
            s_src_d   = acc1;
            if (sel_last) begin
                state_d = IDLE;
                ptr_d   = ~acc1;
            end else begin
                state_d = acc1 ? LOCK1 : LOCK0;
            end
        end else if (S_ready) begin
            s_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= 1'b0;
            s_valid_q <= 1'b0;
            s_last_q  <= 1'b0;
            s_src_q   <= 1'b0;
            s_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            s_valid_q <= s_valid_d;
            s_last_q  <= s_last_d;
            s_src_q   <= s_src_d;
            s_data_q  <= s_data_d;
        end
    end

    assign S_data  = s_data_q;
    assign S_valid = s_valid_q;
    assign S_last  = s_last_q;
    assign S_src   = s_src_q;

`ifdef MUX2V1_ARB_CNT_EN
    localparam int unsigned CNT_W = 16;

    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    // Completed-packet counters, wrapping naturally at full scale.
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (acc0 && E0_last) cnt0_d = CNT_W'(cnt0_q + CNT_W'(1));
        if (acc1 && E1_last) cnt1_d = CNT_W'(cnt1_q + CNT_W'(1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;
`endif

endmodule
